// File: rtl/ball_ctrl.sv
// Ball owner: holds position/direction, steps at a programmable rate and resolves
// wall, paddle and brick bounces. All outputs are registered.
module ball_ctrl #(
  parameter int COORD_W   = 10,
  parameter int SCREEN_W  = 640,
  parameter int SCREEN_H  = 480,
  parameter int BALL_SIZE = 20,
  parameter int PADDLE_W  = 80,
  parameter int PADDLE_Y  = 440,
  parameter int SPEED     = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               launch,
  input  logic [24:0]        delay_done,
  input  logic [COORD_W-1:0] paddle_x,
  input  logic               brick_hit_v,
  input  logic               brick_hit_h,
  output logic [COORD_W-1:0] ball_x,
  output logic [COORD_W-1:0] ball_y,
  output logic               dir_x,
  output logic               dir_y,
  output logic               moving,
  output logic               bounce_ack,
  output logic               ball_lost,
  output logic [2:0]         state_dbg
);

  localparam int XW    = COORD_W + 1;
  localparam int CNT_W = 25;

  localparam logic [XW-1:0] X_MAX     = XW'(SCREEN_W - BALL_SIZE);
  localparam logic [XW-1:0] SZ_W      = XW'(BALL_SIZE);
  localparam logic [XW-1:0] HALF_BALL = XW'(BALL_SIZE / 2);
  localparam logic [XW-1:0] HALF_PAD  = XW'(PADDLE_W / 2);
  localparam logic [XW-1:0] PW_W      = XW'(PADDLE_W);
  localparam logic [XW-1:0] PY_W      = XW'(PADDLE_Y);
  localparam logic [XW-1:0] SH_W      = XW'(SCREEN_H);
  localparam logic [XW-1:0] SPD_W     = XW'(SPEED);

  localparam logic [COORD_W-1:0] X_RESET = COORD_W'((SCREEN_W - BALL_SIZE) / 2);
  localparam logic [COORD_W-1:0] Y_HOME  = COORD_W'(PADDLE_Y - BALL_SIZE);
  localparam logic [COORD_W-1:0] X_EDGE  = COORD_W'(SCREEN_W - BALL_SIZE);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    WAIT   = 3'd1,
    STEP   = 3'd2,
    SETTLE = 3'd3,
    CHECK  = 3'd4,
    LOST   = 3'd5
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [COORD_W-1:0] ball_x_q, ball_x_d;
  logic [COORD_W-1:0] ball_y_q, ball_y_d;
  logic               dir_x_q, dir_x_d;
  logic               dir_y_q, dir_y_d;
  logic               moving_q, moving_d;
  logic               bounce_ack_q, bounce_ack_d;
  logic               ball_lost_q, ball_lost_d;

  // Widened copies so adding sizes/offsets never wraps.
  logic [XW-1:0] bx_w, by_w, px_w;
  logic [XW-1:0] idle_raw, idle_x;
  logic [XW-1:0] step_x, step_y, x_inc;
  logic [XW-1:0] bottom, ball_right, pad_right, ball_ctr, pad_ctr;
  logic          on_paddle;

  always_comb begin
    bx_w       = {1'b0, ball_x_q};
    by_w       = {1'b0, ball_y_q};
    px_w       = {1'b0, paddle_x};
    idle_raw   = px_w + HALF_PAD - HALF_BALL;
    idle_x     = (idle_raw > X_MAX) ? X_MAX : idle_raw;
    x_inc      = bx_w + SPD_W;
    if (dir_x_q) step_x = (x_inc > X_MAX) ? X_MAX : x_inc;
    else         step_x = (bx_w < SPD_W) ? '0 : bx_w - SPD_W;
    if (dir_y_q) step_y = by_w + SPD_W;
    else         step_y = (by_w < SPD_W) ? '0 : by_w - SPD_W;
    bottom     = by_w + SZ_W;
    ball_right = bx_w + SZ_W;
    pad_right  = px_w + PW_W;
    ball_ctr   = bx_w + HALF_BALL;
    pad_ctr    = px_w + HALF_PAD;
    on_paddle  = dir_y_q && (bottom >= PY_W) && (bottom <= PY_W + SPD_W) &&
                 (ball_right >= px_w) && (bx_w <= pad_right);
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    ball_x_d     = ball_x_q;
    ball_y_d     = ball_y_q;
    dir_x_d      = dir_x_q;
    dir_y_d      = dir_y_q;
    bounce_ack_d = 1'b0;

    case (state_q)
      IDLE: begin
        ball_x_d = idle_x[COORD_W-1:0];
        ball_y_d = Y_HOME;
        if (launch) begin
          dir_x_d = 1'b1;
          dir_y_d = 1'b0;
          cnt_d   = '0;
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (cnt_q >= delay_done) begin
          cnt_d   = '0;
          state_d = STEP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      STEP: begin
        ball_x_d = step_x[COORD_W-1:0];
        ball_y_d = step_y[COORD_W-1:0];
        state_d  = SETTLE;
      end
      SETTLE: state_d = CHECK;
      CHECK: begin
        if (bottom >= SH_W) begin
          state_d = LOST;
        end else begin
          // Later rules override earlier ones on the same axis.
          if (brick_hit_v || brick_hit_h) bounce_ack_d = 1'b1;
          if (brick_hit_v) dir_y_d = ~dir_y_q;
          if (brick_hit_h) dir_x_d = ~dir_x_q;
          if (on_paddle) begin
            dir_y_d = 1'b0;
            dir_x_d = (ball_ctr >= pad_ctr);
          end
          if (ball_x_q == '0)    dir_x_d = 1'b1;
          if (ball_x_q == X_EDGE) dir_x_d = 1'b0;
          if (ball_y_q == '0)    dir_y_d = 1'b1;
          state_d = WAIT;
        end
      end
      LOST: begin
        if (launch) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    moving_d    = (state_d == WAIT) || (state_d == STEP) ||
                  (state_d == SETTLE) || (state_d == CHECK);
    ball_lost_d = (state_d == LOST);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      ball_x_q     <= X_RESET;
      ball_y_q     <= Y_HOME;
      dir_x_q      <= 1'b1;
      dir_y_q      <= 1'b0;
      moving_q     <= 1'b0;
      bounce_ack_q <= 1'b0;
      ball_lost_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      ball_x_q     <= ball_x_d;
      ball_y_q     <= ball_y_d;
      dir_x_q      <= dir_x_d;
      dir_y_q      <= dir_y_d;
      moving_q     <= moving_d;
      bounce_ack_q <= bounce_ack_d;
      ball_lost_q  <= ball_lost_d;
    end
  end

  assign ball_x     = ball_x_q;
  assign ball_y     = ball_y_q;
  assign dir_x      = dir_x_q;
  assign dir_y      = dir_y_q;
  assign moving     = moving_q;
  assign bounce_ack = bounce_ack_q;
  assign ball_lost  = ball_lost_q;
  assign state_dbg  = state_q;

endmodule
